// File: rtl/charge_spike_scanner.sv
// ============================================================================
// Module   : charge_spike_scanner
// Brief    : Scans packed membrane charges, streams firing neuron indices,
//            then pulses done/clear. Optional SPIKE_COUNT_EN adds spike_count_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module charge_spike_scanner #(
    parameter int N = 256
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      start_i,
    input  logic [7:0]                threshold_i,
    output logic [$clog2(N/4)-1:0]    count_o,
    input  logic [31:0]               charge_i,
    output logic                      spike_valid_o,
    input  logic                      spike_ready_i,
    output logic [$clog2(N)-1:0]      spike_addr_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      clear_o
`ifdef SPIKE_COUNT_EN
    ,
    output logic [$clog2(N):0]        spike_count_o
`endif
);

    localparam int c_WORD_W = $clog2(N/4);
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(N/4 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_WORD_W-1:0]   r_word;
    logic [3:0]            r_mask;
    logic [7:0]            r_thr;
    logic [3:0]            w_fire;
    logic [3:0]            w_rest;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        logic [1:0] k;
        if (m[0])      k = 2'd0;
        else if (m[1]) k = 2'd1;
        else if (m[2]) k = 2'd2;
        else           k = 2'd3;
        return k;
    endfunction

    generate
        for (genvar k = 0; k < 4; k++) begin : g_cmp
            assign w_fire[k] = $signed(charge_i[8*k +: 8]) >= $signed(r_thr);
        end
    endgenerate

    // Mask with its lowest set bit removed: the spike being accepted this cycle
    assign w_rest  = r_mask & (r_mask - 4'd1);
    assign count_o = r_word;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state       <= S_IDLE;
            r_word        <= '0;
            r_mask        <= '0;
            r_thr         <= '0;
            spike_valid_o <= 1'b0;
            spike_addr_o  <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            clear_o       <= 1'b0;
`ifdef SPIKE_COUNT_EN
            spike_count_o <= '0;
`endif
        end else begin
            done_o  <= 1'b0;
            clear_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_thr   <= threshold_i;
                        r_word  <= '0;
                        busy_o  <= 1'b1;
                        r_state <= S_FETCH;
`ifdef SPIKE_COUNT_EN
                        spike_count_o <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    r_mask <= w_fire;
                    if (|w_fire) begin
                        spike_valid_o <= 1'b1;
                        spike_addr_o  <= {r_word, f_lowest(w_fire)};
                        r_state       <= S_EMIT;
                    end else if (r_word == c_LAST_WORD) begin
                        done_o  <= 1'b1;
                        clear_o <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_word <= r_word + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (spike_ready_i) begin
                        r_mask <= w_rest;
`ifdef SPIKE_COUNT_EN
                        spike_count_o <= spike_count_o + 1'b1;
`endif
                        if (|w_rest) begin
                            spike_addr_o <= {r_word, f_lowest(w_rest)};
                        end else begin
                            spike_valid_o <= 1'b0;
                            if (r_word == c_LAST_WORD) begin
                                done_o  <= 1'b1;
                                clear_o <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_word  <= r_word + 1'b1;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
